// File: rtl/native_port_router_if.sv
// Native memory port bundle: command, write-data and read-data channels.
// Master issues commands and write data; slave returns read data.
interface native_port_router_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 256
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_first;
    logic              cmd_last;
    logic              cmd_we;
    logic              cmd_mw;
    logic [ADDR_W-1:0] cmd_addr;

    logic                wdata_valid;
    logic                wdata_ready;
    logic                wdata_first;
    logic                wdata_last;
    logic [DATA_W-1:0]   wdata_data;
    logic [DATA_W/8-1:0] wdata_we;

    logic              rdata_valid;
    logic              rdata_ready;
    logic              rdata_first;
    logic              rdata_last;
    logic [DATA_W-1:0] rdata_data;

    modport master (
        output cmd_valid, cmd_first, cmd_last, cmd_we, cmd_mw, cmd_addr,
        input  cmd_ready,
        output wdata_valid, wdata_first, wdata_last, wdata_data, wdata_we,
        input  wdata_ready,
        input  rdata_valid, rdata_first, rdata_last, rdata_data,
        output rdata_ready
    );

    modport slave (
        input  cmd_valid, cmd_first, cmd_last, cmd_we, cmd_mw, cmd_addr,
        output cmd_ready,
        input  wdata_valid, wdata_first, wdata_last, wdata_data, wdata_we,
        output wdata_ready,
        output rdata_valid, rdata_first, rdata_last, rdata_data,
        input  rdata_ready
    );
endinterface

// File: rtl/native_port_router.sv
// Steers host native commands to one of two controller ports by address bit
// and returns read data in issue order using per-type port-ID order FIFOs.
module native_port_router #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 256,
    parameter int SEL_BIT = 0,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    native_port_router_if.slave   h,
    native_port_router_if.master  p0,
    native_port_router_if.master  p1,
    output logic [CNT_W-1:0]      wr_pending,
    output logic [CNT_W-1:0]      rd_pending
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] wr_q;
    logic [DEPTH-1:0] rd_q;
    logic [PW-1:0]    wr_wp, wr_rp;
    logic [PW-1:0]    rd_wp, rd_rp;

    logic wr_full, wr_empty, rd_full, rd_empty;
    logic wr_head, rd_head;
    logic sel, is_wr, space;
    logic wd_ok, rd_ok;
    logic wr_push, wr_pop, rd_push, rd_pop;

    assign wr_full  = (wr_pending == CNT_W'(DEPTH));
    assign rd_full  = (rd_pending == CNT_W'(DEPTH));
    assign wr_empty = (wr_pending == '0);
    assign rd_empty = (rd_pending == '0);
    assign wr_head  = wr_q[wr_rp];
    assign rd_head  = rd_q[rd_rp];

    // Write data follows the port recorded at the write FIFO head
    assign wd_ok = !rst && !wr_empty;
    assign h.wdata_ready = wd_ok &&
        (wr_head ? p1.wdata_ready : p0.wdata_ready);
    assign p0.wdata_valid = wd_ok && !wr_head && h.wdata_valid;
    assign p1.wdata_valid = wd_ok && wr_head && h.wdata_valid;
    assign p0.wdata_first = h.wdata_first;
    assign p1.wdata_first = h.wdata_first;
    assign p0.wdata_last  = h.wdata_last;
    assign p1.wdata_last  = h.wdata_last;
    assign p0.wdata_data  = h.wdata_data;
    assign p1.wdata_data  = h.wdata_data;
    assign p0.wdata_we    = h.wdata_we;
    assign p1.wdata_we    = h.wdata_we;

    assign rd_ok = !rst && !rd_empty;
    assign h.rdata_valid = rd_ok &&
        (rd_head ? p1.rdata_valid : p0.rdata_valid);
    assign h.rdata_first = rd_head ? p1.rdata_first : p0.rdata_first;
    assign h.rdata_last  = rd_head ? p1.rdata_last  : p0.rdata_last;
    assign h.rdata_data  = rd_head ? p1.rdata_data  : p0.rdata_data;
    assign p0.rdata_ready = rd_ok && !rd_head && h.rdata_ready;
    assign p1.rdata_ready = rd_ok && rd_head && h.rdata_ready;

    assign wr_pop = h.wdata_valid && h.wdata_ready && h.wdata_last;
    assign rd_pop = h.rdata_valid && h.rdata_ready && h.rdata_last;

    // A same-cycle pop frees a slot, so a full FIFO can still accept
    assign sel   = h.cmd_addr[SEL_BIT];
    assign is_wr = h.cmd_we;
    assign space = is_wr ? (!wr_full || wr_pop) : (!rd_full || rd_pop);

    assign p0.cmd_valid = !rst && h.cmd_valid && space && !sel;
    assign p1.cmd_valid = !rst && h.cmd_valid && space && sel;
    assign h.cmd_ready  = !rst && space &&
        (sel ? p1.cmd_ready : p0.cmd_ready);
    assign p0.cmd_first = h.cmd_first;
    assign p1.cmd_first = h.cmd_first;
    assign p0.cmd_last  = h.cmd_last;
    assign p1.cmd_last  = h.cmd_last;
    assign p0.cmd_we    = h.cmd_we;
    assign p1.cmd_we    = h.cmd_we;
    assign p0.cmd_mw    = h.cmd_mw;
    assign p1.cmd_mw    = h.cmd_mw;
    assign p0.cmd_addr  = h.cmd_addr;
    assign p1.cmd_addr  = h.cmd_addr;

    assign wr_push = h.cmd_valid && h.cmd_ready && is_wr;
    assign rd_push = h.cmd_valid && h.cmd_ready && !is_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_wp      <= '0;
            wr_rp      <= '0;
            rd_wp      <= '0;
            rd_rp      <= '0;
            wr_pending <= '0;
            rd_pending <= '0;
        end else begin
            if (wr_push) begin
                wr_q[wr_wp] <= sel;
                wr_wp       <= wr_wp + 1'b1;
            end
            if (wr_pop) wr_rp <= wr_rp + 1'b1;
            if (rd_push) begin
                rd_q[rd_wp] <= sel;
                rd_wp       <= rd_wp + 1'b1;
            end
            if (rd_pop) rd_rp <= rd_rp + 1'b1;
            wr_pending <= wr_pending + CNT_W'(wr_push) - CNT_W'(wr_pop);
            rd_pending <= rd_pending + CNT_W'(rd_push) - CNT_W'(rd_pop);
        end
    end
endmodule

// File: tb/tb_native_port_router.sv
// Directed bench for native_port_router: routing, ordering, FIFO limits,
// stalls and reset.
module tb_native_port_router;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] wr_pending, rd_pending;
    int total = 0;
    int bad = 0;

    native_port_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) h_if ();
    native_port_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
    native_port_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();

    native_port_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_BIT(0), .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h(h_if),
        .p0(p0_if),
        .p1(p1_if),
        .wr_pending(wr_pending),
        .rd_pending(rd_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] vr();
        return {h_if.cmd_ready, h_if.wdata_ready, h_if.rdata_valid,
                p0_if.cmd_valid, p1_if.cmd_valid,
                p0_if.wdata_valid, p1_if.wdata_valid,
                p0_if.rdata_ready, p1_if.rdata_ready};
    endfunction

    task automatic cmd(input logic v, input logic we, input logic [25:0] a);
        h_if.cmd_valid = v;
        h_if.cmd_we    = we;
        h_if.cmd_mw    = 1'b0;
        h_if.cmd_first = 1'b1;
        h_if.cmd_last  = 1'b1;
        h_if.cmd_addr  = a;
    endtask

    logic [255:0] pat;

    initial begin
        pat = {32{8'hA5}};
        cmd(1'b0, 1'b0, 26'h0);
        h_if.wdata_valid = 1'b0;
        h_if.wdata_first = 1'b0;
        h_if.wdata_last  = 1'b0;
        h_if.wdata_data  = '0;
        h_if.wdata_we    = '0;
        h_if.rdata_ready = 1'b1;
        p0_if.cmd_ready = 1'b1;
        p1_if.cmd_ready = 1'b1;
        p0_if.wdata_ready = 1'b1;
        p1_if.wdata_ready = 1'b1;
        p0_if.rdata_valid = 1'b0;
        p1_if.rdata_valid = 1'b0;
        p0_if.rdata_first = 1'b1;
        p1_if.rdata_first = 1'b1;
        p0_if.rdata_last  = 1'b1;
        p1_if.rdata_last  = 1'b1;
        p0_if.rdata_data  = '0;
        p1_if.rdata_data  = '0;

        // reset holds every valid/ready low even with traffic offered
        cmd(1'b1, 1'b0, 26'h0);
        tick(); tick();
        #1;
        check("rst_vr", 256'(vr()), 256'h0);
        check("rst_wrp", 256'(wr_pending), 256'd0);
        check("rst_rdp", 256'(rd_pending), 256'd0);
        cmd(1'b0, 1'b0, 26'h0);
        rst = 1'b0;
        tick();

        // two reads, data returns out of order from the ports
        cmd(1'b1, 1'b0, 26'h0);
        #1;
        check("rd0_p0v", 256'({p0_if.cmd_valid, p1_if.cmd_valid}), 256'b10);
        check("rd0_rdy", 256'(h_if.cmd_ready), 256'd1);
        tick();
        cmd(1'b1, 1'b0, 26'h1);
        #1;
        check("rd1_p1v", 256'({p0_if.cmd_valid, p1_if.cmd_valid}), 256'b01);
        tick();
        cmd(1'b0, 1'b0, 26'h0);
        #1;
        check("rd_pend2", 256'(rd_pending), 256'd2);
        p1_if.rdata_valid = 1'b1;
        p1_if.rdata_data  = 256'h11;
        #1;
        check("p1_early_hv", 256'(h_if.rdata_valid), 256'd0);
        check("p1_early_rdy", 256'(p1_if.rdata_ready), 256'd0);
        tick();
        p0_if.rdata_valid = 1'b1;
        p0_if.rdata_data  = 256'h22;
        #1;
        check("p0_data_hv", 256'(h_if.rdata_valid), 256'd1);
        check("p0_data", h_if.rdata_data, 256'h22);
        check("p0_rrdy", 256'({p0_if.rdata_ready, p1_if.rdata_ready}),
              256'b10);
        tick();
        p0_if.rdata_valid = 1'b0;
        #1;
        check("p1_data_hv", 256'(h_if.rdata_valid), 256'd1);
        check("p1_data", h_if.rdata_data, 256'h11);
        check("rd_pend1", 256'(rd_pending), 256'd1);
        tick();
        p1_if.rdata_valid = 1'b0;
        #1;
        check("rd_pend0", 256'(rd_pending), 256'd0);
        check("rd_empty_hv", 256'(h_if.rdata_valid), 256'd0);

        // two-beat write to port 1
        cmd(1'b1, 1'b1, 26'h3);
        #1;
        check("wr_p1cv", 256'({p0_if.cmd_valid, p1_if.cmd_valid}), 256'b01);
        tick();
        cmd(1'b0, 1'b0, 26'h0);
        #1;
        check("wr_pend1", 256'(wr_pending), 256'd1);
        h_if.wdata_valid = 1'b1;
        h_if.wdata_first = 1'b1;
        h_if.wdata_last  = 1'b0;
        h_if.wdata_data  = pat;
        h_if.wdata_we    = '1;
        #1;
        check("wd_route", 256'({h_if.wdata_ready, p0_if.wdata_valid,
              p1_if.wdata_valid}), 256'b101);
        check("wd_data", p1_if.wdata_data, pat);
        check("wd_we", 256'(p1_if.wdata_we), 256'(32'hFFFF_FFFF));
        tick();
        check("wr_pend_mid", 256'(wr_pending), 256'd1);
        h_if.wdata_first = 1'b0;
        h_if.wdata_last  = 1'b1;
        tick();
        check("wr_pend_done", 256'(wr_pending), 256'd0);

        // write data with no outstanding write command is blocked
        for (int i = 0; i < 10; i++) begin
            #1;
            check("wd_orphan", 256'({h_if.wdata_ready, p0_if.wdata_valid,
                  p1_if.wdata_valid}), 256'b000);
            tick();
        end
        h_if.wdata_valid = 1'b0;

        // fill read FIFO, write still accepted, push+pop while full
        cmd(1'b1, 1'b0, 26'h0);
        repeat (16) tick();
        check("full_cnt", 256'(rd_pending), 256'd16);
        check("full_stall", 256'({h_if.cmd_ready, p0_if.cmd_valid}),
              256'b00);
        cmd(1'b1, 1'b1, 26'h2);
        #1;
        check("full_wr_ok", 256'(h_if.cmd_ready), 256'd1);
        tick();
        check("full_wr_cnt", 256'(wr_pending), 256'd1);
        cmd(1'b1, 1'b0, 26'h0);
        p0_if.rdata_valid = 1'b1;
        #1;
        check("full_bypass", 256'({h_if.cmd_ready, p0_if.cmd_valid}),
              256'b11);
        tick();
        check("full_pp_cnt", 256'(rd_pending), 256'd16);
        cmd(1'b0, 1'b0, 26'h0);
        h_if.wdata_valid = 1'b1;
        h_if.wdata_last  = 1'b1;
        #1;
        check("wd_p0_route", 256'({p0_if.wdata_valid, p1_if.wdata_valid}),
              256'b10);
        tick();
        h_if.wdata_valid = 1'b0;
        repeat (15) tick();
        p0_if.rdata_valid = 1'b0;
        #1;
        check("drain_wr", 256'(wr_pending), 256'd0);
        check("drain_rd", 256'(rd_pending), 256'd0);

        // port 1 back-pressure does not push; port 0 unaffected
        p1_if.cmd_ready = 1'b0;
        cmd(1'b1, 1'b0, 26'h1);
        #1;
        check("p1_bp", 256'({h_if.cmd_ready, p1_if.cmd_valid}), 256'b01);
        tick();
        check("p1_bp_cnt", 256'(rd_pending), 256'd0);
        cmd(1'b1, 1'b0, 26'h0);
        #1;
        check("p0_ok", 256'({h_if.cmd_ready, p0_if.cmd_valid}), 256'b11);
        tick();
        check("p0_ok_cnt", 256'(rd_pending), 256'd1);
        p1_if.cmd_ready = 1'b1;

        // reset in the middle of traffic
        repeat (4) tick();
        check("pre_rst_cnt", 256'(rd_pending), 256'd5);
        h_if.wdata_valid  = 1'b1;
        p0_if.rdata_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_vr", 256'(vr()), 256'h0);
        tick();
        check("mid_rst_rdp", 256'(rd_pending), 256'd0);
        check("mid_rst_wrp", 256'(wr_pending), 256'd0);
        cmd(1'b0, 1'b0, 26'h0);
        h_if.wdata_valid  = 1'b0;
        p0_if.rdata_valid = 1'b0;
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/native_port_router.md
Name: native_port_router

Overview:
- Sits directly upstream of the dual-native-port memory controller core.
- Takes a single host native port and steers each command to controller port 0 or port 1 by one address bit.
- Steers each command's write data to the same controller port.
- Merges read data from both ports back to the host in command-issue order, using two port-ID order FIFOs.

Parameters:
ADDR_W, 26, native command address width
DATA_W, 256, native data width; byte-enable width is DATA_W/8
SEL_BIT, 0, address bit that selects the port (0 -> port 0, 1 -> port 1)
DEPTH, 16, entries in each order FIFO; power of 2, at least 2
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
h_cmd_valid / h_cmd_ready  in / out  1  host command handshake
h_cmd_first, h_cmd_last, h_cmd_we, h_cmd_mw  in  1  host command flags
h_cmd_addr  in  ADDR_W  host command address
h_wdata_valid / h_wdata_ready  in / out  1  host write-data handshake
h_wdata_first, h_wdata_last  in  1  host write-data beat flags
h_wdata_data  in  DATA_W  host write data
h_wdata_we  in  DATA_W/8  host write byte enables
h_rdata_valid / h_rdata_ready  out / in  1  host read-data handshake
h_rdata_first, h_rdata_last  out  1  host read-data beat flags
h_rdata_data  out  DATA_W  host read data
pN_cmd_valid / pN_cmd_ready  out / in  1  port N command handshake (N = 0, 1)
pN_cmd_first, pN_cmd_last, pN_cmd_we, pN_cmd_mw  out  1  port N command flags
pN_cmd_addr  out  ADDR_W  port N address, passed unchanged
pN_wdata_valid / pN_wdata_ready  out / in  1  port N write-data handshake
pN_wdata_first, pN_wdata_last  out  1  port N write-data beat flags
pN_wdata_data  out  DATA_W  port N write data
pN_wdata_we  out  DATA_W/8  port N write byte enables
pN_rdata_valid / pN_rdata_ready  in / out  1  port N read-data handshake
pN_rdata_first, pN_rdata_last  in  1  port N read-data beat flags
pN_rdata_data  in  DATA_W  port N read data
wr_pending  out  CNT_W  write order FIFO occupancy
rd_pending  out  CNT_W  read order FIFO occupancy

Behaviour:
- Clock and reset: all state uses clk; rst is synchronous and active-high.
- Reset:
  - Both FIFOs empty; wr_pending = rd_pending = 0.
  - While rst=1, all valid and ready outputs are forced to 0.
- Command path (zero latency, combinational):
  - sel = h_cmd_addr[SEL_BIT].
  - The command is a write when h_cmd_we=1; masked writes (mw=1) also carry we=1.
  - space = (write ? wr FIFO not full : rd FIFO not full).
  - pN_cmd_valid = h_cmd_valid & space & (sel==N).
  - h_cmd_ready = space & p[sel]_cmd_ready.
  - Payload fields are broadcast to both ports.
  - A handshake pushes sel into the wr FIFO or the rd FIFO.
- Write data:
  - Routed to the port at the wr FIFO head.
  - The other port's wdata_valid is 0.
  - When the wr FIFO is empty, h_wdata_ready=0; data never precedes its command.
  - A beat with last=1 and a completed handshake pops the wr FIFO.
- Read data:
  - h_rdata is muxed from the port at the rd FIFO head.
  - Only that port sees rdata_ready = h_rdata_ready; the other port's rdata_ready is 0.
  - When the rd FIFO is empty, h_rdata_valid=0 and both rdata_ready=0.
  - A handshake with last=1 pops the rd FIFO.
- Order FIFOs:
  - Register array of DEPTH x 1 bit, with log2(DEPTH)-bit wrapping pointers and a CNT_W counter.
  - Simultaneous push and pop: counter unchanged, both pointers advance. This is legal when full, because the pop frees the slot in the same cycle.
  - When full with no pop, commands of that type stall; commands of the other type are unaffected.
- Ordering across types: reads and writes are ordered only within their own type. Read-after-write ordering across ports is the controller's responsibility.
- No combinational path from any pN_*_valid input back to that same port's *_ready output.

Test Plan:
- After rst release: issue reads to addr 0x0 and 0x1 (SEL_BIT=0) -> p0 then p1 cmd_valid, rd_pending=2. Return data from p1 first -> h_rdata_valid=0 until p0 data arrives; host receives p0 data, then p1 data.
- Write to addr 0x3 with wdata 0xA5.., we=all ones -> p1_wdata_valid=1, p0_wdata_valid=0, wr_pending goes 1 -> 0 on the last beat.
- h_wdata_valid=1 with no write command outstanding -> h_wdata_ready=0 and no port wdata_valid for 10 cycles.
- Issue 16 reads with p0 rdata held off -> rd_pending=16, h_cmd_ready=0 for a 17th read, while a write is still accepted. Pop one with a simultaneous new read -> count stays 16.
- p1_cmd_ready=0 with a command to p1 -> h_cmd_ready=0, no FIFO push; commands to p0 are unaffected once presented.
- Assert rst mid-traffic with rd_pending=5 -> next cycle rd_pending=0, wr_pending=0, all valid/ready outputs 0.
